// File: rtl/bel_cbfly_pipe.sv
// Pipelined radix-2 complex butterfly: X = A + B, Y = A - B with per-beat
// divide-by-2 scaling or saturation, two register stages under valid/ready.

module bel_cbfly_lane #(
  parameter int word_width = 16
) (
  input  logic [word_width:0]   full_i,
  input  logic                  scale_i,
  output logic [word_width-1:0] res_o,
  output logic                  clamp_o
);
  localparam int W = word_width;

  // Overflow when the two top bits of the full-width value disagree.
  always_comb begin
    res_o   = full_i[W-1:0];
    clamp_o = 1'b0;
    if (scale_i) begin
      res_o = full_i[W:1];
    end else if (full_i[W] != full_i[W-1]) begin
      clamp_o = 1'b1;
      res_o   = {full_i[W], {(W-1){~full_i[W]}}};
    end
  end
endmodule

module bel_cbfly_pipe #(
  parameter int word_width = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic                  scale_i,
  input  logic [word_width-1:0] a_re_i,
  input  logic [word_width-1:0] a_im_i,
  input  logic [word_width-1:0] b_re_i,
  input  logic [word_width-1:0] b_im_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [word_width-1:0] x_re_o,
  output logic [word_width-1:0] x_im_o,
  output logic [word_width-1:0] y_re_o,
  output logic [word_width-1:0] y_im_o,
  output logic                  ovf_o
);
  localparam int W         = word_width;
  localparam int NUM_LANES = 4;

  // Lane order: 0 = x_re, 1 = x_im, 2 = y_re, 3 = y_im.
  typedef struct packed {
    logic [NUM_LANES-1:0][W:0] full;
    logic                      scale;
  } s1_t;

  typedef struct packed {
    logic [NUM_LANES-1:0][W-1:0] res;
    logic                        ovf;
  } s2_t;

  logic [2:1] vld_pipe_q, vld_pipe_d;
  s1_t        s1_q, s1_d;
  s2_t        s2_q, s2_d;
  logic       s1_adv, s2_adv;

  logic [W:0] a_re_x, a_im_x, b_re_x, b_im_x;
  logic [NUM_LANES-1:0][W-1:0] lane_res;
  logic [NUM_LANES-1:0]        lane_clamp;

  assign a_re_x = {a_re_i[W-1], a_re_i};
  assign a_im_x = {a_im_i[W-1], a_im_i};
  assign b_re_x = {b_re_i[W-1], b_re_i};
  assign b_im_x = {b_im_i[W-1], b_im_i};

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    bel_cbfly_lane #(.word_width(W)) u_lane (
      .full_i  (s1_q.full[l]),
      .scale_i (s1_q.scale),
      .res_o   (lane_res[l]),
      .clamp_o (lane_clamp[l])
    );
  end

  always_comb begin
    s2_adv     = ~vld_pipe_q[2] | out_ready_i;
    s1_adv     = ~vld_pipe_q[1] | s2_adv;
    vld_pipe_d = vld_pipe_q;
    s1_d       = s1_q;
    s2_d       = s2_q;
    if (s2_adv) begin
      vld_pipe_d[2] = vld_pipe_q[1];
      if (vld_pipe_q[1]) begin
        s2_d.res = lane_res;
        s2_d.ovf = |lane_clamp;
      end
    end
    // Data only loads with a real beat so idle operands never reach the outputs.
    if (s1_adv) begin
      vld_pipe_d[1] = in_valid_i;
      if (in_valid_i) begin
        s1_d.full[0] = a_re_x + b_re_x;
        s1_d.full[1] = a_im_x + b_im_x;
        s1_d.full[2] = a_re_x - b_re_x;
        s1_d.full[3] = a_im_x - b_im_x;
        s1_d.scale   = scale_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      vld_pipe_q <= '0;
      s1_q       <= '0;
      s2_q       <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
    end
  end

  assign in_ready_o  = s1_adv;
  assign out_valid_o = vld_pipe_q[2];
  assign x_re_o      = s2_q.res[0];
  assign x_im_o      = s2_q.res[1];
  assign y_re_o      = s2_q.res[2];
  assign y_im_o      = s2_q.res[3];
  assign ovf_o       = s2_q.ovf;
endmodule
